// File: rtl/gol_pkg.sv
// Shared types, rule constants and the B3/S23 cell rule for the Game-of-Life engine.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } gol_state_t;

  // Neighbour counts are 4 bits wide (0..8).
  localparam logic [3:0] BIRTH_N = 4'd3;
  localparam logic [3:0] SURV_LO = 4'd2;
  localparam logic [3:0] SURV_HI = 4'd3;

  // Next state of one cell from its current state and live-neighbour count.
  function automatic logic gol_rule(input logic alive, input logic [3:0] n);
    if (alive) begin
      return (n >= SURV_LO) && (n <= SURV_HI);
    end
    return n == BIRTH_N;
  endfunction

endpackage

// File: rtl/gol_cell.sv
// Combinational single-cell evaluator: counts the eight neighbours and applies B3/S23.
module gol_cell
  import gol_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       self_bit,
  output logic       next_bit
);

  logic [3:0] cnt;

  // Population count of the neighbour bits, then the birth/survival rule.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(nbr[i]);
    end
    next_bit = gol_rule(self_bit, cnt);
  end

endmodule

// File: rtl/gol_engine.sv
// Parametrised Game-of-Life engine: grid register, load/step/run FSM,
// saturating generation counter, and stable/extinct detection with auto-halt.
module gol_engine
  import gol_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 step,
  input  logic                 run,
  input  logic                 wrap,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 extinct,
  output logic                 busy
);

  localparam int N = ROWS * COLS;
  localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

  gol_state_t       state_q, state_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;

  logic [N-1:0]     next_grid;

  // One evaluator per cell. Neighbours inside the grid connect directly; those
  // that fall off an edge see the wrapped-around cell only when wrap is set.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr;

      for (genvar k = 0; k < 9; k++) begin : g_nbr
        if (k != 4) begin : g_use
          localparam int  DR     = k / 3 - 1;
          localparam int  DC     = k % 3 - 1;
          localparam int  RR_RAW = r + DR;
          localparam int  CC_RAW = c + DC;
          localparam bit  INSIDE = (RR_RAW >= 0) && (RR_RAW < ROWS) &&
                                   (CC_RAW >= 0) && (CC_RAW < COLS);
          localparam int  RR     = (RR_RAW + ROWS) % ROWS;
          localparam int  CC     = (CC_RAW + COLS) % COLS;
          localparam int  BI     = (k < 4) ? k : k - 1;
          if (INSIDE) begin : g_in
            assign nbr[BI] = grid_q[RR*COLS+CC];
          end else begin : g_edge
            assign nbr[BI] = wrap & grid_q[RR*COLS+CC];
          end
        end
      end

      gol_cell u_cell (
        .nbr      (nbr),
        .self_bit (grid_q[r*COLS+c]),
        .next_bit (next_grid[r*COLS+c])
      );
    end
  end

  // Control: decide whether this cycle advances, then classify the outcome.
  always_comb begin
    logic advance;
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    advance   = 1'b0;

    case (state_q)
      IDLE: begin
        advance = step | run;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (run) advance = 1'b1;
        else     state_d = IDLE;
      end
      default: ;  // HALT: frozen until load or reset
    endcase

    if (load) begin
      grid_d    = seed;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
      state_d   = IDLE;
    end else if (advance) begin
      if (next_grid == grid_q) begin
        stable_d = 1'b1;
        state_d  = HALT;
      end else begin
        grid_d = next_grid;
        gen_d  = (gen_q == '1) ? gen_q : gen_q + GEN_ONE;
        if (next_grid == '0) begin
          extinct_d = 1'b1;
          state_d   = HALT;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_gol_engine.sv
// Self-checking bench for gol_engine: directed scenarios plus random control,
// all compared every cycle against a cell-by-cell reference model.
module tb_gol_engine;

  localparam int R = 8;
  localparam int C = 8;

  logic        clk = 1'b0;
  logic        reset, load, step, run, wrap;
  logic [63:0] seed;

  logic [63:0] grid_a, grid_b;
  logic [15:0] gen_a;
  logic [3:0]  gen_b;
  logic        stable_a, extinct_a, busy_a;
  logic        stable_b, extinct_b, busy_b;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [63:0] m_grid;
  int          m_gen16, m_gen4;
  bit          m_stable, m_extinct;
  int          m_mode;  // 0 idle, 1 running, 2 halted

  always #5 clk = ~clk;

  gol_engine #(.ROWS(R), .COLS(C), .GEN_W(16)) dut_a (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step),
    .run(run), .wrap(wrap), .grid(grid_a), .gen_count(gen_a),
    .stable(stable_a), .extinct(extinct_a), .busy(busy_a)
  );

  gol_engine #(.ROWS(R), .COLS(C), .GEN_W(4)) dut_b (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step),
    .run(run), .wrap(wrap), .grid(grid_b), .gen_count(gen_b),
    .stable(stable_b), .extinct(extinct_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Conway successor computed directly from the rules on a 2-D view of the grid.
  function automatic logic [63:0] life(input logic [63:0] g, input bit w);
    logic [63:0] nx = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (w) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
              continue;
            end
            n += int'(g[rr*C+cc]);
          end
        end
        if (g[r*C+c]) nx[r*C+c] = (n == 2 || n == 3);
        else          nx[r*C+c] = (n == 3);
      end
    end
    return nx;
  endfunction

  task automatic model_update();
    bit adv = 0;
    logic [63:0] nx;
    if (reset) begin
      m_grid = '0; m_gen16 = 0; m_gen4 = 0; m_stable = 0; m_extinct = 0; m_mode = 0;
    end else if (load) begin
      m_grid = seed; m_gen16 = 0; m_gen4 = 0; m_stable = 0; m_extinct = 0; m_mode = 0;
    end else begin
      if (m_mode == 0) begin
        adv = step || run;
        if (run) m_mode = 1;
      end else if (m_mode == 1) begin
        if (run) adv = 1;
        else     m_mode = 0;
      end
      if (adv) begin
        nx = life(m_grid, wrap);
        if (nx == m_grid) begin
          m_stable = 1; m_mode = 2;
        end else begin
          m_grid  = nx;
          m_gen16 = (m_gen16 < 65535) ? m_gen16 + 1 : m_gen16;
          m_gen4  = (m_gen4 < 15) ? m_gen4 + 1 : m_gen4;
          if (nx == 0) begin
            m_extinct = 1; m_mode = 2;
          end
        end
      end
    end
  endtask

  // One clock: model follows the sampled inputs, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check("grid",    grid_a,    m_grid);
    check("gen16",   64'(gen_a), 64'(m_gen16));
    check("stable",  64'(stable_a),  64'(m_stable));
    check("extinct", 64'(extinct_a), 64'(m_extinct));
    check("busy",    64'(busy_a),    64'(m_mode == 1));
    check("grid_w4", grid_b,    m_grid);
    check("gen4",    64'(gen_b), 64'(m_gen4));
  endtask

  task automatic clear_ctl();
    reset = 0; load = 0; step = 0; run = 0;
  endtask

  task automatic do_load(input logic [63:0] s);
    seed = s; load = 1; tick(); load = 0;
  endtask

  localparam logic [63:0] BLINKER  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINKER2 = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK    = 64'h0000_0000_0000_0303;
  localparam logic [63:0] GLIDER   = 64'h0000_0000_0007_0402;
  localparam logic [63:0] SINGLE   = 64'h0000_0000_0000_0001;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    clear_ctl();
    wrap = 0; seed = '0;
    m_grid = '0; m_gen16 = 0; m_gen4 = 0; m_stable = 0; m_extinct = 0; m_mode = 0;

    // Reset state.
    reset = 1; tick(); tick(); reset = 0;
    check("rst_grid", grid_a, 64'h0);
    check("rst_busy", 64'(busy_a), 64'h0);

    // 1: blinker, dead edges.
    wrap = 0;
    do_load(BLINKER);
    step = 1; tick(); step = 0;
    check("blink_g1", grid_a, BLINKER2);
    check("blink_c1", 64'(gen_a), 64'd1);
    step = 1; tick(); step = 0;
    check("blink_g2", grid_a, BLINKER);
    check("blink_c2", 64'(gen_a), 64'd2);
    tick();

    // 2: block halts as stable on the first advance.
    do_load(BLOCK);
    run = 1; tick();
    check("block_stable", 64'(stable_a), 64'd1);
    check("block_busy",   64'(busy_a),   64'd0);
    check("block_gen",    64'(gen_a),    64'd0);
    check("block_grid",   grid_a,        BLOCK);
    tick(); run = 0; tick();
    check("block_frozen", grid_a, BLOCK);

    // 3a: glider on a torus returns home after 32 generations.
    wrap = 1;
    do_load(GLIDER);
    run = 1;
    for (int i = 0; i < 32; i++) tick();
    check("glider_wrap_grid", grid_a, GLIDER);
    check("glider_wrap_gen",  64'(gen_a), 64'd32);
    check("glider_wrap_halt", 64'(stable_a | extinct_a), 64'd0);
    check("glider_wrap_busy", 64'(busy_a), 64'd1);
    run = 0; tick();

    // 3b: glider with dead edges becomes a corner block.
    wrap = 0;
    do_load(GLIDER);
    run = 1;
    for (int i = 0; i < 200 && !stable_a && !extinct_a; i++) tick();
    check("glider_dead_stable",  64'(stable_a),  64'd1);
    check("glider_dead_extinct", 64'(extinct_a), 64'd0);
    check("glider_corner", grid_a & 64'hC0C0_0000_0000_0000, 64'hC0C0_0000_0000_0000);
    run = 0; tick();

    // 4: lone cell dies; halted afterwards.
    do_load(SINGLE);
    step = 1; tick(); step = 0;
    check("single_grid",    grid_a, 64'h0);
    check("single_extinct", 64'(extinct_a), 64'd1);
    check("single_gen",     64'(gen_a), 64'd1);
    step = 1; tick(); step = 0;
    run = 1; tick(); tick(); run = 0;
    check("single_hold_gen",  64'(gen_a),  64'd1);
    check("single_hold_busy", 64'(busy_a), 64'd0);

    // 5: load during RUN, reset during RUN, load beats step.
    do_load(BLINKER);
    run = 1; tick(); tick(); tick();
    seed = GLIDER; load = 1; tick(); load = 0; run = 0;
    check("midrun_load_grid", grid_a, GLIDER);
    check("midrun_load_gen",  64'(gen_a), 64'd0);
    check("midrun_load_busy", 64'(busy_a), 64'd0);
    run = 1; tick(); tick();
    reset = 1; tick(); reset = 0; run = 0;
    check("midrun_rst_grid", grid_a, 64'h0);
    check("midrun_rst_gen",  64'(gen_a), 64'd0);
    check("midrun_rst_busy", 64'(busy_a), 64'd0);
    seed = BLINKER; load = 1; step = 1; tick(); load = 0; step = 0;
    check("load_vs_step", grid_a, BLINKER);
    check("load_vs_step_gen", 64'(gen_a), 64'd0);

    // 6: 4-bit counter saturates while the blinker keeps toggling.
    wrap = 0;
    do_load(BLINKER);
    run = 1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_gen4",  64'(gen_b), 64'd15);
    check("sat_gen16", 64'(gen_a), 64'd20);
    check("sat_grid",  grid_b, BLINKER);
    tick();
    check("sat_toggle", grid_b, BLINKER2);
    check("sat_hold",   64'(gen_b), 64'd15);
    run = 0; tick();

    // Random control and seeds against the model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(63) == 0);
      load  = ($urandom_range(15) == 0);
      step  = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) run = ~run;
      if ($urandom_range(5) == 0) wrap = $urandom_range(1);
      if (load) begin
        case ($urandom_range(3))
          0: seed = {$urandom, $urandom};
          1: seed = {$urandom, $urandom} & {$urandom, $urandom};
          2: seed = 64'({$urandom_range(7), 3'b0}) << ($urandom_range(7) * 8) | BLINKER;
          default: seed = GLIDER << $urandom_range(40);
        endcase
      end
      tick();
    end
    clear_ctl();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
